csa_accum: RTL and testbench
============================

# csa_accum

Parametrised carry-save accumulator for the DSP datapath. It takes two WIDTH-bit operands per accepted beat and folds them into a redundant sum/carry state through two 3:2 compressor levels, so there is no carry propagation in the accumulate loop. On the last beat of a packet it resolves the redundant pair with one carry-propagate add. The resolved result is presented on a valid/ready output port. This block succeeds the fixed 48-bit single-level CSA: width is generic, accumulation is packetised, and results are handed off under backpressure.

## Interface
- WIDTH, 48: operand, accumulator and result width (>= 4).
- CNT_W, 8: width of the beat counter.

- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat; transfer occurs when in_valid & in_ready.
- ain  in  WIDTH  operand A, unsigned.
- bin  in  WIDTH  operand B, unsigned.
- in_last  in  1  marks the final beat of a packet; sampled on transfer.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  (sum of all ain+bin in the packet) mod 2^WIDTH.
- cnt  out  CNT_W  beats accepted in the packet, saturating at 2^CNT_W-1.
- ovf  out  1  unsigned overflow of the packet sum. Sticky per packet.

## Operation
- The FSM has three states: ACC, RESOLVE, OUT. Reset state is ACC.
- **ACC:**
  - in_ready=1.
  - Per transfer, level 1 computes (s1,c1)=CSA(s,c,ain) and level 2 computes (s2,c2)=CSA(s1,c1<<1,bin).
  - The registers update as s<=s2 and c<=c2<<1. Left shifts are truncated to WIDTH bits and bit 0 is filled with 0.
  - cnt increments and saturates at 2^CNT_W-1; it never wraps.
  - A transfer with in_last=1 moves the FSM to RESOLVE.
- **RESOLVE:**
  - Lasts exactly one cycle with in_ready=0.
  - result_reg <= s+c mod 2^WIDTH.
  - Next state is OUT.
- **OUT:**
  - out_valid=1 and in_ready=0.
  - result, cnt and ovf are held stable until out_ready=1.
  - On the handshake, s, c, cnt and ovf clear to 0, out_valid drops, and the FSM returns to ACC.
- A single-beat packet (in_last on the first beat) gives cnt=1.
- Empty packets do not exist.
- in_valid while in_ready=0 is ignored. The source holds its data.

## Timing
- Reset values:
  - in_ready=0; it is a register and rises on the first clk edge after rst deasserts.
  - out_valid=0, result=0, cnt=0, ovf=0.
  - s=0, c=0, FSM in ACC.
- Asserting rst at any time, including mid-packet, RESOLVE or OUT, immediately clears all state. A partial packet is discarded with no output.
- Throughput in ACC: one beat per cycle.
- Latency: last beat accepted at edge N. RESOLVE occupies the cycle after edge N, and out_valid=1 after edge N+1.
  - If out_ready=1 during that cycle, the handshake completes at edge N+2 and in_ready=1 again after edge N+2.
  - The minimum packet-to-packet gap is therefore 2 cycles with in_ready=0.
- There is no combinational path from out_ready to in_ready or from in_valid to out_valid.

## Configuration
- Macro: CSA_ACCUM_OVF_EN.
- **Defined:** ovf is set if any of the following is 1 in the packet:
  - a carry MSB discarded by either CSA level;
  - a bit shifted out of c;
  - the carry-out of the RESOLVE add.

  Then ovf=1 exactly when the true unsigned packet sum is >= 2^WIDTH. It clears on the output handshake or on reset.
- **Undefined:** the overflow logic is not built and ovf is tied to 0. All other behaviour is identical.

## Test plan
- **Basic sum:** WIDTH=48, beats (5,7), (10,20), then (1,2) with in_last, out_ready=1. Expect result=45, cnt=3, ovf=0, and out_valid exactly 1 cycle after the RESOLVE cycle.
- **Overflow:** single last beat ain=bin=0xFFFF_FFFF_FFFF. Expect result=0xFFFF_FFFF_FFFE and cnt=1. ovf=1 with CSA_ACCUM_OVF_EN defined, ovf=0 without.
- **Backpressure:** hold out_ready=0 for 5 cycles after out_valid rises while in_valid=1. Expect out_valid, result and cnt stable and in_ready=0 throughout. On release, the next packet (3,4) with in_last yields result=7, cnt=1, with no carry-over from the previous packet.
- **Reset mid-packet:** two beats of (100,100), then pulse rst asynchronously between edges. Expect all outputs 0 immediately. The next packet (1,1) with in_last yields result=2, cnt=1.
- **Count saturation and wrap:** WIDTH=8, CNT_W=2, six beats of (0x80,0x80) with the last flagged. Expect cnt=3 and result=0x00. ovf=1 when the macro is defined.
- **Streaming:** 1000 random packets of length 1–20 with random in_valid/out_ready gaps. result matches the golden sum mod 2^WIDTH, cnt equals the packet length, and ovf matches the golden overflow.

Source files
------------

// File: rtl/csa_accum.sv
// csa_accum: packetised carry-save accumulator.
//
// Each accepted beat folds two unsigned operands into a redundant sum/carry
// pair through two 3:2 compressor levels, so the accumulate loop has no carry
// propagation. The beat flagged in_last ends the packet; the pair is then
// resolved with a single carry-propagate add and the result is offered on a
// valid/ready port until the consumer takes it.
//
// Parameters:
//   WIDTH  operand / accumulator / result width (>= 4)
//   CNT_W  width of the saturating beat counter
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid, in_ready    operand beat handshake (in_ready is registered)
//   ain, bin              unsigned operands, WIDTH bits
//   in_last               final beat of the packet, sampled on transfer
//   out_valid, out_ready  result handshake (out_valid is registered)
//   result                packet sum mod 2^WIDTH
//   cnt                   beats accepted in the packet, saturating
//   ovf                   sticky unsigned overflow of the packet sum
//
// Build option:
//   CSA_ACCUM_OVF_EN  when defined, overflow tracking is built; otherwise
//                     ovf is tied to 0.

module csa_accum #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    typedef enum logic [1:0] {
        ST_ACC     = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_OUT     = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] s1, c1, c1_sh, s2, c2;
    logic [WIDTH-1:0] res_sum;
    logic             xfer;

    // in_ready_q is only ever high in ACC, so it alone qualifies a transfer
    assign xfer = in_valid & in_ready_q;

    // Two 3:2 compressor levels: (s,c,ain) then (s1,c1<<1,bin)
    always_comb begin
        s1    = s_q ^ c_q ^ ain;
        c1    = (s_q & c_q) | (s_q & ain) | (c_q & ain);
        c1_sh = c1 << 1;
        s2    = s1 ^ c1_sh ^ bin;
        c2    = (s1 & c1_sh) | (s1 & bin) | (c1_sh & bin);
    end

`ifdef CSA_ACCUM_OVF_EN
    logic ovf_q, ovf_d;
    logic res_carry;

    assign {res_carry, res_sum} = {1'b0, s_q} + {1'b0, c_q};

    // Every bit of weight 2^WIDTH dropped from the redundant pair means the
    // true sum has already reached 2^WIDTH; otherwise the final add decides.
    always_comb begin
        ovf_d = ovf_q;
        case (state_q)
            ST_ACC: begin
                if (xfer && (c1[WIDTH-1] || c2[WIDTH-1])) begin
                    ovf_d = 1'b1;
                end
            end
            ST_RESOLVE: begin
                if (res_carry) begin
                    ovf_d = 1'b1;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    ovf_d = 1'b0;
                end
            end
            default: ovf_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign res_sum = s_q + c_q;
    assign ovf     = 1'b0;
`endif

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            ST_ACC: begin
                if (xfer) begin
                    s_d = s2;
                    c_d = c2 << 1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (in_last) begin
                        state_d = ST_RESOLVE;
                    end
                end
            end
            ST_RESOLVE: begin
                result_d = res_sum;
                state_d  = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    s_d     = '0;
                    c_d     = '0;
                    cnt_d   = '0;
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase

        // Handshake flags are registered copies of the next state
        in_ready_d  = (state_d == ST_ACC);
        out_valid_d = (state_d == ST_OUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACC;
            s_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cnt       = cnt_q;

endmodule

// File: tb/tb_csa_accum.sv
// Testbench for csa_accum: a 48-bit instance driven through directed and
// streaming packets with a scoreboard, plus an 8-bit / 2-bit-counter
// instance for counter saturation and sum wrap.

module tb_csa_accum;

    localparam int unsigned W  = 48;
    localparam int unsigned CW = 8;

`ifdef CSA_ACCUM_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          in_valid, in_ready, in_last, out_valid, out_ready, ovf;
    logic [W-1:0]  ain, bin, result;
    logic [CW-1:0] cnt;

    logic          in_valid_s, in_ready_s, in_last_s, out_valid_s, out_ready_s, ovf_s;
    logic [7:0]    ain_s, bin_s, result_s;
    logic [1:0]    cnt_s;

    typedef struct {
        logic [W-1:0]  r;
        logic [CW-1:0] n;
        logic          o;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    bit   rand_rdy = 1'b0;

    always #5 clk = ~clk;

    csa_accum #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .ain(ain), .bin(bin), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cnt(cnt), .ovf(ovf)
    );

    csa_accum #(.WIDTH(8), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s), .in_ready(in_ready_s),
        .ain(ain_s), .bin(bin_s), .in_last(in_last_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s),
        .result(result_s), .cnt(cnt_s), .ovf(ovf_s)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic expect_pkt(input logic [W-1:0] r, input logic [CW-1:0] n, input logic o);
        exp_t e;
        e.r = r;
        e.n = n;
        e.o = o;
        sb.push_back(e);
    endtask

    // Drive one beat and return just after the edge that transferred it
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
        int t;
        t = 0;
        in_valid = 1'b1;
        ain      = a;
        bin      = b;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_timeout: in_ready got 0, want 1 (t=%0t)", $time);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_drain: got %0d results outstanding, want 0", nm, sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare each accepted result against the queue head
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got result 0x%0h, want no output", result);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_result", 64'(result), 64'(mon_e.r));
                chk("sb_cnt", 64'(cnt), 64'(mon_e.n));
                chk("sb_ovf", 64'(ovf), 64'(mon_e.o));
            end
        end
    end

    // Random consumer backpressure during the streaming phase
    always @(posedge clk) begin
        #1;
        if (rand_rdy) begin
            out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0]  la [20];
        logic [W-1:0]  lb [20];
        logic [63:0]   ra, rb, sum;
        int            len, sh, beats, t;

        in_valid = 1'b0; ain = '0; bin = '0; in_last = 1'b0; out_ready = 1'b1;
        in_valid_s = 1'b0; ain_s = '0; bin_s = '0; in_last_s = 1'b0; out_ready_s = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_before_edge", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("in_ready_after_edge", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Basic sum: 5+7+10+20+1+2 = 45, with latency checks
        expect_pkt(W'(45), CW'(3), 1'b0);
        send(W'(5), W'(7), 1'b0);
        send(W'(10), W'(20), 1'b0);
        send(W'(1), W'(2), 1'b1);
        @(negedge clk);
        chk("resolve_out_valid", 64'(out_valid), 64'd0);
        chk("resolve_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("out_valid_rise", 64'(out_valid), 64'd1);
        chk("out_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("post_hs_out_valid", 64'(out_valid), 64'd0);
        chk("post_hs_in_ready", 64'(in_ready), 64'd1);
        drain("basic");

        // Overflow: all-ones + all-ones in one beat
        expect_pkt(48'hFFFF_FFFF_FFFE, CW'(1), OVF_ON);
        send(48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 1'b1);
        drain("overflow");

        // Backpressure: hold the result with a beat waiting at the input
        out_ready = 1'b0;
        expect_pkt(W'(18), CW'(1), 1'b0);
        send(W'(9), W'(9), 1'b1);
        in_valid = 1'b1; ain = W'(3); bin = W'(4); in_last = 1'b1;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_result", 64'(result), 64'd18);
            chk("bp_cnt", 64'(cnt), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        expect_pkt(W'(7), CW'(1), 1'b0);
        out_ready = 1'b1;
        send(W'(3), W'(4), 1'b1);
        drain("backpressure");

        // Reset mid-packet discards the partial sum
        send(W'(100), W'(100), 1'b0);
        send(W'(100), W'(100), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        chk("midrst_cnt", 64'(cnt), 64'd0);
        chk("midrst_ovf", 64'(ovf), 64'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        expect_pkt(W'(2), CW'(1), 1'b0);
        send(W'(1), W'(1), 1'b1);
        drain("midreset");

        // Narrow instance: six beats of 0x80+0x80, counter saturates at 3
        in_valid_s = 1'b1; ain_s = 8'h80; bin_s = 8'h80;
        beats = 0;
        t = 0;
        while (beats < 6 && t < 100) begin
            in_last_s = (beats == 5);
            @(negedge clk);
            if (in_ready_s) beats++;
            t++;
            @(posedge clk);
            #1;
        end
        in_valid_s = 1'b0;
        in_last_s  = 1'b0;
        t = 0;
        @(negedge clk);
        while (!out_valid_s && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("sat_out_valid", 64'(out_valid_s), 64'd1);
        chk("sat_result", 64'(result_s), 64'd0);
        chk("sat_cnt", 64'(cnt_s), 64'd3);
        chk("sat_ovf", 64'(ovf_s), 64'(OVF_ON));
        @(posedge clk);
        #1;

        // Streaming: random packets, gaps and consumer stalls
        rand_rdy = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            len = $urandom_range(1, 20);
            sh  = $urandom_range(0, 8);
            sum = '0;
            for (int b = 0; b < len; b++) begin
                ra    = 64'({$urandom(), $urandom()}) >> (16 + sh);
                rb    = 64'({$urandom(), $urandom()}) >> (16 + sh);
                la[b] = ra[W-1:0];
                lb[b] = rb[W-1:0];
                sum   = sum + ra + rb;
            end
            expect_pkt(sum[W-1:0], CW'(len), OVF_ON && ((sum >> W) != 64'd0));
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                send(la[b], lb[b], b == len - 1);
            end
        end
        @(negedge clk);
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain("stream");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
